// File: rtl/multicycle_main_fsm.sv
// Main control FSM of the multi-cycle RV32I core.
// Define ILLEGAL_TRAP_EN to trap on unknown opcodes.
module multicycle_main_fsm #(
  parameter int INSTRET_W = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [6:0]           opcode,
  input  logic [2:0]           f3,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic                 adr_src,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 old_pc_write,
  output logic                 pc_write,
  output logic [2:0]           imm_src,
  output logic [1:0]           alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic [1:0]           result_src,
  output logic                 reg_write,
  output logic                 instr_done,
`ifdef ILLEGAL_TRAP_EN
  output logic                 illegal_op,
`endif
  output logic [INSTRET_W-1:0] instret
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEM_ADR, MEM_READ,
    MEM_WB, MEM_WRITE, EXEC_R, EXEC_I,
    LUI, ALU_WB, JAL, EXEC_JALR,
    JALR_PC, BRANCH, TRAP
  } state_e;

  state_e                 state_q, state_d;
  logic [INSTRET_W-1:0]   instret_q, instret_d;
  logic                   taken;

  always_comb begin
    unique case (f3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      3'b100:  taken = ~zero;
      3'b101:  taken = zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    case (opcode)
      OP_STORE: imm_src = 3'b001;
      OP_BR:    imm_src = 3'b010;
      OP_JAL:   imm_src = 3'b011;
      OP_LUI:   imm_src = 3'b100;
      default:  imm_src = 3'b000;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    adr_src      = 1'b0;
    mem_write    = 1'b0;
    ir_write     = 1'b0;
    old_pc_write = 1'b0;
    pc_write     = 1'b0;
    alu_src_a    = 2'b00;
    alu_src_b    = 2'b00;
    alu_op       = 2'b00;
    result_src   = 2'b00;
    reg_write    = 1'b0;
    instr_done   = 1'b0;
    case (state_q)
      FETCH: begin
        alu_src_b    = 2'b10;
        result_src   = 2'b10;
        pc_write     = mem_ready;
        ir_write     = mem_ready;
        old_pc_write = mem_ready;
        if (mem_ready) state_d = DECODE;
      end
      DECODE: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        case (opcode)
          OP_LOAD, OP_STORE: state_d = MEM_ADR;
          OP_R:              state_d = EXEC_R;
          OP_I:              state_d = EXEC_I;
          OP_JAL:            state_d = JAL;
          OP_JALR:           state_d = EXEC_JALR;
          OP_BR:             state_d = BRANCH;
          OP_LUI:            state_d = LUI;
`ifdef ILLEGAL_TRAP_EN
          default:           state_d = TRAP;
`else
          default:           state_d = FETCH;
`endif
        endcase
      end
      MEM_ADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = (opcode == OP_LOAD) ? MEM_READ
                                        : MEM_WRITE;
      end
      MEM_READ: begin
        adr_src = 1'b1;
        if (mem_ready) state_d = MEM_WB;
      end
      MEM_WB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      MEM_WRITE: begin
        adr_src    = 1'b1;
        mem_write  = 1'b1;
        instr_done = mem_ready;
        if (mem_ready) state_d = FETCH;
      end
      EXEC_R: begin
        alu_src_a = 2'b10;
        alu_op    = 2'b10;
        state_d   = ALU_WB;
      end
      EXEC_I: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        alu_op    = 2'b10;
        state_d   = ALU_WB;
      end
      LUI: begin
        alu_src_a = 2'b11;
        alu_src_b = 2'b01;
        state_d   = ALU_WB;
      end
      ALU_WB: begin
        reg_write  = 1'b1;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      // ALU recomputes old_pc+4 here for rd while PC takes ALUOut
      JAL, JALR_PC: begin
        alu_src_a = 2'b01;
        alu_src_b = 2'b10;
        pc_write  = 1'b1;
        state_d   = ALU_WB;
      end
      EXEC_JALR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        state_d   = JALR_PC;
      end
      BRANCH: begin
        alu_src_a  = 2'b10;
        alu_op     = 2'b01;
        pc_write   = taken;
        instr_done = 1'b1;
        state_d    = FETCH;
      end
      TRAP:    state_d = TRAP;
      default: state_d = FETCH;
    endcase
  end

  always_comb begin
    instret_d = instret_q;
    if (instr_done) instret_d = instret_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      instret_q <= instret_d;
    end
  end

  assign instret = instret_q;
`ifdef ILLEGAL_TRAP_EN
  assign illegal_op = (state_q == TRAP);
`endif

endmodule

// File: doc/multicycle_main_fsm.md
Name: multicycle_main_fsm

Overview:
Main control state machine of the multi-cycle RV32I core. It sits directly upstream of the ALU-decode and datapath-select logic.
- Sequences each instruction through fetch, decode, execute, memory and writeback states.
- Drives the datapath strobes and mux selects: adr_src, ir_write, pc_write, old_pc_write, alu_src_a/b, result_src, reg_write, mem_write.
- Emits alu_op for the ALU-function decoder.
- Supports variable-latency memory through a mem_ready handshake.

Parameters:
INSTRET_W, 32, width of the retired-instruction counter instret.

Ports:
clk  input  1  system clock.
rst  input  1  synchronous, active-high reset.
opcode  input  7  instruction[6:0] from the instruction register.
f3  input  3  instruction[14:12], used for branch-taken decision.
zero  input  1  ALU zero flag for the current cycle.
mem_ready  input  1  memory access completes this cycle.
adr_src  output  1  memory address select: 0 = PC, 1 = ALUOut.
mem_write  output  1  data memory write strobe.
ir_write  output  1  instruction register load.
old_pc_write  output  1  old-PC register load.
pc_write  output  1  PC register load.
imm_src  output  3  immediate format: 000 I, 001 S, 010 B, 011 J, 100 U.
alu_src_a  output  2  ALU A select: 00 PC, 01 old PC, 10 rs1, 11 zero.
alu_src_b  output  2  ALU B select: 00 rs2, 01 immediate, 10 constant 4.
alu_op  output  2  00 add, 01 branch compare, 10 funct-decoded.
result_src  output  2  result select: 00 ALUOut, 01 memory data, 10 ALU result.
reg_write  output  1  register-file write strobe.
instr_done  output  1  one-cycle pulse on the last cycle of each instruction.
instret  output  INSTRET_W  count of retired instructions, wraps modulo 2^INSTRET_W.

Behaviour:
Output style
- Moore outputs decoded combinationally from the state register.
- Exceptions: the fetch strobes depend on mem_ready, and pc_write in BRANCH depends on zero and f3.
- imm_src is decoded from opcode in every state: lw and jalr → I; sw → S; branch → B; jal → J; lui → U; R-type → 000.
- Any output not listed for a state is 0.

Reset
- rst high at a clock edge sets state = FETCH and instret = 0, from any state, including mid-access.
- Outputs are then FETCH decodes; with mem_ready low, every strobe is 0.

States, outputs and transitions
- FETCH: adr_src=0, a=00, b=10, alu_op=00, result_src=10. While mem_ready=1, pc_write, ir_write and old_pc_write are all 1. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
- DECODE: a=01, b=01, alu_op=00, computing old_pc+imm into ALUOut. Next state by opcode:
  - 0000011 or 0100011 → MEM_ADR
  - 0110011 → EXEC_R
  - 0010011 → EXEC_I
  - 1101111 → JAL
  - 1100111 → EXEC_JALR
  - 1100011 → BRANCH
  - 0110111 → LUI
  - any other opcode → see Optional Feature.
- MEM_ADR: a=10, b=01, alu_op=00. Next: MEM_READ if opcode is lw, otherwise MEM_WRITE.
- MEM_READ: adr_src=1. Stays until mem_ready=1, then → MEM_WB.
- MEM_WB: result_src=01, reg_write=1, instr_done=1. Next: FETCH.
- MEM_WRITE: adr_src=1, mem_write=1 held until mem_ready=1, then instr_done=1 and → FETCH.
- EXEC_R: a=10, b=00, alu_op=10. Next: ALU_WB.
- EXEC_I: a=10, b=01, alu_op=10. Next: ALU_WB.
- LUI: a=11, b=01, alu_op=00. Next: ALU_WB.
- ALU_WB: result_src=00, reg_write=1, instr_done=1. Next: FETCH.
- JAL: a=01, b=10, alu_op=00, result_src=00, pc_write=1. Next: ALU_WB, which writes old_pc+4 to rd.
- EXEC_JALR: a=10, b=01, alu_op=00. Next: JALR_PC.
- JALR_PC: same outputs as JAL. Next: ALU_WB.
- BRANCH: a=10, b=00, alu_op=01, result_src=00, instr_done=1. Next: FETCH.
  - pc_write = taken.
  - taken by f3: 000 → zero; 001 → ~zero; 100 → ~zero (ALU does slt); 101 → zero; any other f3 → 0.

Counter
- instret increments on every cycle where instr_done=1.
- instret wraps from all-ones to 0.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Without the macro: an unknown opcode in DECODE → FETCH with no strobes asserted; instr_done=0 and instret is not incremented.
- With the macro: an unknown opcode in DECODE → TRAP state.
  - TRAP is absorbing: all strobes are 0 and the state machine stays there until rst.
  - An extra output port illegal_op (1 bit) equals 1 exactly while in TRAP and 0 after reset.

Test Plan:
- rst held 2 cycles while mid MEM_READ, mem_ready=0 → state FETCH, instret=0, all strobes 0.
- add with mem_ready always 1 → FETCH, DECODE, EXEC_R, ALU_WB; 4 cycles; reg_write=1 only in cycle 4; instret +1.
- lw with mem_ready low 3 cycles in MEM_READ → adr_src=1 held 4 cycles; one reg_write pulse with result_src=01; total 8 cycles.
- beq: zero=1 → pc_write=1 in BRANCH; zero=0 → pc_write=0; bne with zero=0 → pc_write=1; each 3 cycles.
- jal → pc_write pulses in FETCH and JAL; reg_write in ALU_WB; 4 cycles. jalr → 5 cycles.
- opcode 1111111 → with ILLEGAL_TRAP_EN, illegal_op=1 and the machine stays for 10 cycles; without it, returns to FETCH with instret unchanged.
